// File: rtl/fracn_pkg.sv
// Shared types and constants for the fractional-N multi-modulus divider.
// Holds the FSM state enum, the default minimum ratio and the modulator width.
package fracn_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        COUNT = 2'd2
    } state_t;

    localparam int MIN_DIV_DEF = 4;
    localparam int MASH_W      = 4;

endpackage

// File: rtl/fracn_mmd_if.sv
// Control/status bundle between the modulator side and the divider.
// master: drives en, n_int, mash_out; slave: drives div_out, mod_adv, div_val, busy.
interface fracn_mmd_if #(
    parameter int CNT_W = 9
);
    import fracn_pkg::*;

    logic              en;
    logic [7:0]        n_int;
    logic [MASH_W-1:0] mash_out;
    logic              div_out;
    logic              mod_adv;
    logic [CNT_W-1:0]  div_val;
    logic              busy;

    modport master (
        output en, n_int, mash_out,
        input  div_out, mod_adv, div_val, busy
    );

    modport slave (
        input  en, n_int, mash_out,
        output div_out, mod_adv, div_val, busy
    );

endinterface

// File: rtl/fracn_ratio_calc.sv
// Combinational ratio: n_int + sign-extended mash_out, clamped to [MIN_DIV, 2^CNT_W-1].
// Ports: n_int, mash_out in; d (clamped ratio) and clamp (d was limited) out.
module fracn_ratio_calc #(
    parameter int CNT_W   = 9,
    parameter int MIN_DIV = 4
) (
    input  logic [7:0]                   n_int,
    input  logic [fracn_pkg::MASH_W-1:0] mash_out,
    output logic [CNT_W-1:0]             d,
    output logic                         clamp
);
    import fracn_pkg::*;

    // Wide enough for the raw sum and signed compare against both limits.
    localparam int SW = (CNT_W + 2 > 10) ? CNT_W + 2 : 10;

    localparam logic signed [SW-1:0] LO = SW'(MIN_DIV);
    localparam logic signed [SW-1:0] HI = SW'((2 ** CNT_W) - 1);

    logic signed [SW-1:0] n_ext;
    logic signed [SW-1:0] m_ext;
    logic signed [SW-1:0] sum;

    assign n_ext = {{(SW - 8){1'b0}}, n_int};
    assign m_ext = {{(SW - MASH_W){mash_out[MASH_W-1]}}, mash_out};
    assign sum   = n_ext + m_ext;

    always_comb begin
        d     = sum[CNT_W-1:0];
        clamp = 1'b0;
        if (sum < LO) begin
            d     = LO[CNT_W-1:0];
            clamp = 1'b1;
        end else if (sum > HI) begin
            d     = HI[CNT_W-1:0];
            clamp = 1'b1;
        end
    end

endmodule

// File: rtl/fracn_mmd_divider.sv
// Fractional-N MMD divider: counts D VCO cycles per period, D = n_int + mash_out.
// Ports: clk, rst_n, bus (fracn_mmd_if.slave); sat_sticky if FRACN_MMD_SAT_FLAG_EN.
module fracn_mmd_divider #(
    parameter int CNT_W   = 9,
    parameter int MIN_DIV = fracn_pkg::MIN_DIV_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    fracn_mmd_if.slave  bus
`ifdef FRACN_MMD_SAT_FLAG_EN
    ,
    output logic        sat_sticky
`endif
);
    import fracn_pkg::*;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] div_val_q;
    logic             div_out_q;
    logic             mod_adv_q;
    logic [CNT_W-1:0] d;
    logic             clamp;
    logic [CNT_W-1:0] half;

    fracn_ratio_calc #(
        .CNT_W   (CNT_W),
        .MIN_DIV (MIN_DIV)
    ) u_calc (
        .n_int    (bus.n_int),
        .mash_out (bus.mash_out),
        .d        (d),
        .clamp    (clamp)
    );

    // ceil(D/2): div_out stays high while the next cnt is at least this.
    assign half = (div_val_q >> 1)
                + {{(CNT_W - 1){1'b0}}, div_val_q[0]};

`ifndef FRACN_MMD_SAT_FLAG_EN
    logic unused_clamp;
    assign unused_clamp = clamp;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            div_val_q <= '0;
            div_out_q <= 1'b0;
            mod_adv_q <= 1'b0;
`ifdef FRACN_MMD_SAT_FLAG_EN
            sat_sticky <= 1'b0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    div_out_q <= 1'b0;
                    mod_adv_q <= 1'b0;
                    if (bus.en) state <= LOAD;
                end
                LOAD, COUNT: begin
                    if (state == LOAD || (cnt == '0 && bus.en)) begin
                        // Sample cycle: next edge starts a new period.
                        state     <= COUNT;
                        cnt       <= d - 1'b1;
                        div_val_q <= d;
                        div_out_q <= 1'b1;
                        mod_adv_q <= 1'b1;
`ifdef FRACN_MMD_SAT_FLAG_EN
                        if (clamp) sat_sticky <= 1'b1;
`endif
                    end else if (cnt == '0) begin
                        state     <= IDLE;
                        div_out_q <= 1'b0;
                        mod_adv_q <= 1'b0;
                    end else begin
                        cnt       <= cnt - 1'b1;
                        mod_adv_q <= 1'b0;
                        div_out_q <= ((cnt - 1'b1) >= half);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.div_out = div_out_q;
    assign bus.mod_adv = mod_adv_q;
    assign bus.div_val = div_val_q;
    assign bus.busy    = (state != IDLE);

endmodule

// File: tb/tb_fracn_mmd_divider.sv
// Directed self-checking bench for fracn_mmd_divider.
// Measures period length, high time and strobe count against hand-computed values.
module tb_fracn_mmd_divider;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   n_chk = 0;
    int   n_err = 0;

    fracn_mmd_if #(.CNT_W(9)) bus ();

`ifdef FRACN_MMD_SAT_FLAG_EN
    logic sat_sticky;
`endif

    fracn_mmd_divider #(
        .CNT_W   (9),
        .MIN_DIV (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus)
`ifdef FRACN_MMD_SAT_FLAG_EN
        ,
        .sat_sticky (sat_sticky)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    // Call at the negedge of a period's first cycle; returns at the next one.
    task automatic meas(output int per, output int hi, output int adv);
        per = 0;
        hi  = 0;
        adv = 0;
        do begin
            per++;
            hi  += int'(bus.div_out);
            adv += int'(bus.mod_adv);
            @(negedge clk);
        end while (!bus.mod_adv && per < 1000);
    endtask

    // Set inputs; skip the already-loaded period, then measure the new one.
    task automatic run(input string tag, input int n, input int m,
                       input int e_per, input int e_hi);
        int per, hi, adv, dv;
        bus.n_int    = 8'(n);
        bus.mash_out = 4'(m);
        meas(per, hi, adv);
        dv = int'(bus.div_val);
        meas(per, hi, adv);
        check({tag, "_per"}, per, e_per);
        check({tag, "_hi"}, hi, e_hi);
        check({tag, "_adv"}, adv, 1);
        check({tag, "_dv"}, dv, e_per);
    endtask

    initial begin
        int per, hi, adv, n;
        bus.en       = 1'b0;
        bus.n_int    = 8'd10;
        bus.mash_out = 4'd0;
        #3 rst_n = 1'b0;
        step(3);
        check("rst_div_out", int'(bus.div_out), 0);
        check("rst_mod_adv", int'(bus.mod_adv), 0);
        check("rst_div_val", int'(bus.div_val), 0);
        check("rst_busy", int'(bus.busy), 0);
`ifdef FRACN_MMD_SAT_FLAG_EN
        check("rst_sat", int'(sat_sticky), 0);
`endif
        rst_n = 1'b1;
        step(3);
        check("idle_no_en_busy", int'(bus.busy), 0);

        bus.en = 1'b1;
        step(1);
        check("load_busy", int'(bus.busy), 1);
        check("load_mod_adv", int'(bus.mod_adv), 0);
        step(1);
        check("start_mod_adv", int'(bus.mod_adv), 1);
        check("start_div_out", int'(bus.div_out), 1);
        check("start_div_val", int'(bus.div_val), 10);
        meas(per, hi, adv);
        check("d10_per", per, 10);
        check("d10_hi", hi, 5);
        check("d10_adv", adv, 1);

        run("d7", 7, 0, 7, 3);
        run("d13", 10, 3, 13, 6);
        run("d7m", 10, -3, 7, 3);
`ifdef FRACN_MMD_SAT_FLAG_EN
        check("sat_clear", int'(sat_sticky), 0);
`endif
        run("clamp_lo", 5, -3, 4, 2);
`ifdef FRACN_MMD_SAT_FLAG_EN
        check("sat_set", int'(sat_sticky), 1);
`endif
        run("d259", 255, 4, 259, 129);

        // Alternating modulator; each change lands mid-period.
        bus.n_int    = 8'd20;
        bus.mash_out = 4'd1;
        meas(per, hi, adv);
        for (int k = 0; k < 4; k++) begin
            bus.mash_out = (k % 2 == 0) ? 4'hF : 4'd1;
            meas(per, hi, adv);
            check($sformatf("alt%0d_per", k), per, (k % 2 == 0) ? 21 : 19);
        end

        // en dropped three cycles into a D=10 period.
        bus.n_int    = 8'd10;
        bus.mash_out = 4'd0;
        meas(per, hi, adv);
        step(3);
        bus.en = 1'b0;
        n = 0;
        while (bus.busy && n < 50) begin
            n++;
            step(1);
        end
        check("en_drop_rem", n, 7);
        check("en_drop_div_out", int'(bus.div_out), 0);
        step(2);
        check("en_drop_idle", int'(bus.busy), 0);
        check("en_drop_dv_hold", int'(bus.div_val), 10);
        bus.en = 1'b1;
        step(1);
        check("reen_load", int'(bus.busy), 1);
        check("reen_load_adv", int'(bus.mod_adv), 0);
        step(1);
        check("reen_start_adv", int'(bus.mod_adv), 1);

        // Asynchronous reset mid-period.
        step(4);
        #2 rst_n = 1'b0;
        #1;
        check("arst_div_out", int'(bus.div_out), 0);
        check("arst_busy", int'(bus.busy), 0);
        check("arst_div_val", int'(bus.div_val), 0);
        check("arst_mod_adv", int'(bus.mod_adv), 0);
`ifdef FRACN_MMD_SAT_FLAG_EN
        check("arst_sat", int'(sat_sticky), 0);
`endif
        step(2);
        rst_n = 1'b1;
        step(1);
        check("post_rst_load", int'(bus.busy), 1);
        check("post_rst_load_adv", int'(bus.mod_adv), 0);
        step(1);
        check("post_rst_start", int'(bus.mod_adv), 1);
        check("post_rst_dv", int'(bus.div_val), 10);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/fracn_mmd_divider.md
FRACN_MMD_DIVIDER -- requirements
Module: fracn_mmd_divider

Interface
REQ-001 Parameter CNT_W, default 9: width of the divide counter and of div_val.
REQ-002 Parameter MIN_DIV, default 4: smallest divide ratio the block will execute.
REQ-003 clk  input  1  VCO-side clock; all state advances on its rising edge.
REQ-004 rst_n  input  1  reset; asynchronous, active-low.
REQ-005 en  input  1  run enable, level-sensitive.
REQ-006 n_int  input  8  unsigned integer divide ratio.
REQ-007 mash_out  input  4  signed two's-complement modulator correction (legal range -3..+4).
REQ-008 div_out  output  1  divided clock, registered.
REQ-009 mod_adv  output  1  one-cycle strobe that advances the upstream modulator, registered.
REQ-010 div_val  output  CNT_W  divide ratio D of the current period, registered.
REQ-011 busy  output  1  high when the state is not IDLE.

Function
REQ-012 States SHALL be IDLE, LOAD and COUNT; reset enters IDLE.
REQ-013 IDLE -> LOAD on the first edge with en=1; LOAD -> COUNT unconditionally after one cycle.
REQ-014 Sample cycles are the LOAD cycle and every COUNT cycle with cnt==0 and en=1; n_int and mash_out are read only in sample cycles.
REQ-015 D = zero-extended n_int + sign-extended mash_out, computed at ≥10 bits signed; D<MIN_DIV clamps to MIN_DIV; D>2^CNT_W-1 clamps to 2^CNT_W-1.
REQ-016 The edge after a sample cycle SHALL load cnt=D-1, div_val=D, div_out=1 and mod_adv=1; this cycle is the first cycle of the period.
REQ-017 cnt decrements by 1 per cycle; each period lasts exactly D cycles, with no gap between back-to-back periods.
REQ-018 div_out is high for the first floor(D/2) cycles of a period and low for the remaining ceil(D/2) cycles.
REQ-019 mod_adv is high only in the first cycle of each period.
REQ-020 en deasserted mid-period: the current period completes unchanged, then COUNT -> IDLE at cnt==0 with div_out=0.
REQ-021 en toggling within a period has no effect; only en at the cnt==0 cycle matters.
REQ-022 IDLE: div_out=0, mod_adv=0, busy=0, div_val holds its last value.

Reset
REQ-023 Asserting rst_n low SHALL immediately force state=IDLE, cnt=0, div_out=0, mod_adv=0, div_val=0 and busy=0, including mid-period.
REQ-024 After reset release, the first LOAD occurs only on an edge with en=1.

Configuration
REQ-025 Macro FRACN_MMD_SAT_FLAG_EN defined: adds output sat_sticky (1 bit), set on the edge after any sample cycle whose D was clamped, and cleared only by reset.
REQ-026 FRACN_MMD_SAT_FLAG_EN undefined: no sat_sticky port and no associated logic; clamping behaviour is identical.

Structure
REQ-027 Shared package fracn_pkg holds the state enum (IDLE/LOAD/COUNT), the MIN_DIV default, and the modulator output width (4).
REQ-028 One sub-module, fracn_ratio_calc: combinational sign-extend, add and clamp, producing D and a clamp flag.

Verification
REQ-029 n_int=10, mash_out=0, en=1 -> periods of 10 cycles, div_out high 5 / low 5, mod_adv once per period, div_val=10.
REQ-030 n_int=7, mash_out=0 -> div_out high 3 / low 4; n_int=10, mash_out=+3 -> period 13; mash_out=-3 -> period 7.
REQ-031 n_int=5, mash_out=-3 -> D=2 clamped to 4, div_val=4, sat_sticky=1 when the macro is defined.
REQ-032 mash_out sequence +1,-1 repeated with n_int=20 -> periods alternate 21,19; mash_out changed mid-period is ignored until the cnt==0 cycle.
REQ-033 en dropped 3 cycles into a D=10 period -> 7 more cycles, then IDLE and busy=0; en reasserted -> LOAD, then a new period one cycle later.
REQ-034 rst_n pulsed low mid-period -> all outputs 0 asynchronously; after release with en=1 -> LOAD, then period start.
